shift_reg_burst: RTL and testbench
==================================

// Module: shift_reg_burst
// PURPOSE
//  Parametrised successor to the 4-bit load/enable shift register.
//  WIDTH-bit register with async reset, sync parallel load and single-step shifting.
//  Four shift modes: logical right, logical left, rotate right, arithmetic right.
//  Adds a burst engine: one start command shifts 'amount' positions autonomously, with busy/done handshake.
// PARAMETERS
//  WIDTH  8  register width, >= 2
//  CNT_W  4  width of amount and of the internal step counter
// PORTS
//  clk      in   1      rising-edge clock
//  areset   in   1      asynchronous, active-high reset
//  load     in   1      sync parallel load of in
//  in       in   WIDTH  parallel load data
//  ena      in   1      single-step shift (idle only)
//  mode     in   2      00 lsr, 01 lsl, 10 ror, 11 asr
//  ser_in   in   1      fill bit for lsr/lsl
//  start    in   1      begin burst (idle only)
//  amount   in   CNT_W  burst step count
//  Q        out  WIDTH  register contents
//  ser_out  out  1      bit shifted out on the most recent step
//  busy     out  1      burst in progress
//  done     out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset: areset=1 forces Q=0, ser_out=0, busy=0, done=0, FSM=IDLE, count=0 immediately, regardless of clk.
//   This holds mid-burst too.
//  Step functions (W=WIDTH):
//   lsr Q<={ser_in,Q[W-1:1]}, ser_out<=Q[0]
//   lsl Q<={Q[W-2:0],ser_in}, ser_out<=Q[W-1]
//   ror Q<={Q[0],Q[W-1:1]},   ser_out<=Q[0]
//   asr Q<={Q[W-1],Q[W-1:1]}, ser_out<=Q[0]
//   ser_in is sampled live on every step.
//  Priority per edge: areset > load > burst step > start > ena.
//  load: Q<=in; ser_out unchanged.
//   If busy, load also aborts the burst: FSM->IDLE, busy<=0, no done pulse.
//   A start or ena in the same cycle as load is dropped.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE:
//   start=1, amount>0: latch mode, count<=amount, busy<=1, ->SHIFT. No shift on this edge.
//   start=1, amount=0: ->DONE. Q unchanged, busy stays 0.
//   ena=1 without start: one step using the live mode.
//  SHIFT (one step per edge, using the latched mode):
//   Each edge: one step, count<=count-1.
//   The step taken at count==1: ->DONE, busy<=0.
//   Live mode, start and ena are ignored.
//  DONE: done=1 for exactly one cycle, then ->IDLE. Inputs start/ena are ignored in this cycle.
//  Latency: start sampled at edge k with amount=N>0.
//   Steps occur at edges k+1..k+N.
//   busy=1 from edge k to edge k+N; done=1 from edge k+N to edge k+N+1.
//  amount > WIDTH is legal: steps simply continue (e.g. lsr fills entirely with ser_in).
//  Max burst is 2^CNT_W-1 steps; no wrap of count.
//  All outputs are registered; no combinational input->output paths.
// TESTING (WIDTH=8, CNT_W=4)
//  1 areset pulse mid-burst, asserted between clock edges -> Q=00, ser_out=0, busy=0, done=0 at once;
//    next start behaves normally.
//  2 load A5; mode=00, ser_in=0, ena 1 cycle -> Q=52, ser_out=1; mode=01, ser_in=1, ena -> Q=A5, ser_out=0.
//  3 load 81; start, amount=3, mode=10 -> Q=C0,60,30 on successive edges;
//    busy high 3 cycles; done one pulse; ser_out=0.
//  4 load 90; start, amount=2, mode=11; toggle mode mid-burst -> Q=C8 then E4 (latched mode used); done pulses once.
//  5 load 3C; start, amount=5, mode=00; load 0F at 2nd step -> Q=0F, busy=0, no done pulse.
//  6 start with amount=0 -> done for 1 cycle, busy never 1, Q unchanged.
//    start/ena while busy -> ignored; Q follows only burst steps.

Source files
------------

// File: rtl/shift_reg_burst.sv
// shift_reg_burst: WIDTH-bit load/shift register with four shift modes and an autonomous multi-step burst engine
module shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] Q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [1:0] mode_q, step_mode;
  logic stepping, go;
  logic [WIDTH-1:0] q_step;
  logic so_step;
  assign step_mode = state == SHIFT ? mode_q : mode;
  assign stepping = !load && (state == SHIFT || (state == IDLE && !start && ena));
  assign go = !load && state == IDLE && start && amount != '0;
  always_comb begin
    q_step = step_mode == 2'b00 ? {ser_in, Q[WIDTH-1:1]} :
             step_mode == 2'b01 ? {Q[WIDTH-2:0], ser_in} :
             step_mode == 2'b10 ? {Q[0], Q[WIDTH-1:1]} :
                                  {Q[WIDTH-1], Q[WIDTH-1:1]};
    so_step = step_mode == 2'b01 ? Q[WIDTH-1] : Q[0];
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state  <= IDLE;
      count  <= '0;
      mode_q <= 2'b00;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      mode_q <= go ? mode : mode_q;
    end
  end
  // load wins over everything and silently aborts a burst
  always_comb begin
    state_nx = state;
    count_nx = count;
    if (load) begin
      state_nx = IDLE;
      count_nx = '0;
    end else if (state == IDLE) begin
      state_nx = start ? (amount == '0 ? DONE : SHIFT) : IDLE;
      count_nx = start ? amount : count;
    end else if (state == SHIFT) begin
      state_nx = count == CNT_W'(1) ? DONE : SHIFT;
      count_nx = count - 1'b1;
    end else begin
      state_nx = IDLE;
    end
  end
  always_comb begin
    busy = state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      Q       <= '0;
      ser_out <= 1'b0;
    end else if (load) begin
      Q <= in;
    end else if (stepping) begin
      Q       <= q_step;
      ser_out <= so_step;
    end
  end
endmodule

// File: tb/tb_shift_reg_burst.sv
// tb_shift_reg_burst: directed vectors with a queue scoreboard checked once per clock edge
module tb_shift_reg_burst;
  logic clk = 0, areset = 1, load = 0, ena = 0, ser_in = 0, start = 0;
  logic [7:0] in = '0;
  logic [1:0] mode = '0;
  logic [3:0] amount = '0;
  logic [7:0] Q;
  logic ser_out, busy, done;
  int tests = 0, fails = 0;
  typedef struct {string name; logic [7:0] q; logic so, b, d;} exp_t;
  exp_t sb[$];

  shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .areset(areset), .load(load), .in(in), .ena(ena), .mode(mode),
    .ser_in(ser_in), .start(start), .amount(amount), .Q(Q), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] q, input logic so, b, d);
    tests++;
    if (Q !== q || ser_out !== so || busy !== b || done !== d) begin
      fails++;
      $display("FAIL %s: got Q=%h ser_out=%b busy=%b done=%b, want Q=%h ser_out=%b busy=%b done=%b",
               name, Q, ser_out, busy, done, q, so, b, d);
    end
  endtask

  // monitor: each entry is the expected state right after the next rising edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, e.q, e.so, e.b, e.d);
    end
  end

  task automatic cyc(input string name, input logic ld, input logic [7:0] din, input logic en,
                     input logic [1:0] md, input logic si, input logic st, input logic [3:0] amt,
                     input logic [7:0] eq, input logic eso, eb, ed);
    exp_t e;
    @(negedge clk);
    load = ld; in = din; ena = en; mode = md; ser_in = si; start = st; amount = amt;
    e.name = name; e.q = eq; e.so = eso; e.b = eb; e.d = ed;
    sb.push_back(e);
  endtask

  initial begin
    #1 chk("reset_state", 8'h00, 0, 0, 0);
    @(negedge clk); areset = 0;
    // single steps
    cyc("ld_a5",     1, 8'hA5, 0, 2'b00, 0, 0, 0, 8'hA5, 0, 0, 0);
    cyc("ena_lsr",   0, 8'h00, 1, 2'b00, 0, 0, 0, 8'h52, 1, 0, 0);
    cyc("ena_lsl",   0, 8'h00, 1, 2'b01, 1, 0, 0, 8'hA5, 0, 0, 0);
    // ror burst of 3
    cyc("ld_81",     1, 8'h81, 0, 2'b00, 0, 0, 0, 8'h81, 0, 0, 0);
    cyc("ror_start", 0, 8'h00, 0, 2'b10, 0, 1, 3, 8'h81, 0, 1, 0);
    cyc("ror_s1",    0, 8'h00, 0, 2'b10, 0, 0, 0, 8'hC0, 1, 1, 0);
    cyc("ror_s2",    0, 8'h00, 0, 2'b10, 0, 0, 0, 8'h60, 0, 1, 0);
    cyc("ror_s3",    0, 8'h00, 0, 2'b10, 0, 0, 0, 8'h30, 0, 0, 1);
    cyc("ror_idle",  0, 8'h00, 0, 2'b10, 0, 0, 0, 8'h30, 0, 0, 0);
    // asr burst ignores live mode changes
    cyc("ld_90",     1, 8'h90, 0, 2'b00, 0, 0, 0, 8'h90, 0, 0, 0);
    cyc("asr_start", 0, 8'h00, 0, 2'b11, 0, 1, 2, 8'h90, 0, 1, 0);
    cyc("asr_s1",    0, 8'h00, 0, 2'b00, 1, 0, 0, 8'hC8, 0, 1, 0);
    cyc("asr_s2",    0, 8'h00, 0, 2'b01, 1, 0, 0, 8'hE4, 0, 0, 1);
    cyc("asr_idle",  0, 8'h00, 0, 2'b00, 0, 0, 0, 8'hE4, 0, 0, 0);
    // load aborts a burst with no done pulse
    cyc("ld_3c",     1, 8'h3C, 0, 2'b00, 0, 0, 0, 8'h3C, 0, 0, 0);
    cyc("ab_start",  0, 8'h00, 0, 2'b00, 0, 1, 5, 8'h3C, 0, 1, 0);
    cyc("ab_s1",     0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h1E, 0, 1, 0);
    cyc("ab_load",   1, 8'h0F, 0, 2'b00, 0, 0, 0, 8'h0F, 0, 0, 0);
    cyc("ab_idle1",  0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h0F, 0, 0, 0);
    cyc("ab_idle2",  0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h0F, 0, 0, 0);
    // zero-length burst
    cyc("z_start",   0, 8'h00, 0, 2'b00, 0, 1, 0, 8'h0F, 0, 0, 1);
    cyc("z_after",   0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h0F, 0, 0, 0);
    // start/ena while busy or done are ignored
    cyc("ig_start",  0, 8'h00, 0, 2'b00, 1, 1, 2, 8'h0F, 0, 1, 0);
    cyc("ig_s1",     0, 8'h00, 1, 2'b01, 1, 1, 3, 8'h87, 1, 1, 0);
    cyc("ig_s2",     0, 8'h00, 1, 2'b01, 1, 1, 3, 8'hC3, 1, 0, 1);
    cyc("ig_done",   0, 8'h00, 1, 2'b01, 1, 1, 1, 8'hC3, 1, 0, 0);
    cyc("ig_idle",   0, 8'h00, 0, 2'b00, 0, 0, 0, 8'hC3, 1, 0, 0);
    // async reset between edges mid-burst
    cyc("rs_start",  0, 8'h00, 0, 2'b10, 0, 1, 4, 8'hC3, 1, 1, 0);
    cyc("rs_s1",     0, 8'h00, 0, 2'b10, 0, 0, 0, 8'hE1, 1, 1, 0);
    @(negedge clk);
    areset = 1;
    #1 chk("async_reset", 8'h00, 0, 0, 0);
    #2 areset = 0;
    cyc("post_start", 0, 8'h00, 0, 2'b01, 1, 1, 1, 8'h00, 0, 1, 0);
    cyc("post_s1",    0, 8'h00, 0, 2'b01, 1, 0, 0, 8'h01, 0, 0, 1);
    cyc("post_idle",  0, 8'h00, 0, 2'b00, 0, 0, 0, 8'h01, 0, 0, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
